// File: rtl/dmem_bus_master.sv
// -----------------------------------------------------------------------------
// dmem_bus_master
//
// Data-memory bus master for the MEM stage. It runs each load or store as one
// transaction on a req/gnt/rvalid bus and holds the pipeline in stall until the
// transaction retires. Load data is extracted from the addressed lane and then
// sign- or zero-extended.
//
// Optional feature (macro DMEM_STORE_BUFFER_EN): stores are posted into a
// one-entry buffer and retire with zero stall. The buffer then drains on its
// own. Without the macro, stores block exactly like loads.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mem_req_i            MEM stage holds a valid load/store (held while stalled)
//   mem_we_i             1 = store, 0 = load
//   mem_addr_i           byte address
//   mem_be_i, mem_wd_i   lane-steered store byte enables and data
//   mem_funct3_i         load type (LB/LH/LW/LBU/LHU)
//   stall_o              freeze the pipeline this cycle
//   rd_valid_o           one-cycle load-result strobe
//   rd_data_o            extended load data, held until the next load retires
//   err_o                one-cycle bus-error pulse
//   bus_req_o .. bus_wdata_o   request channel (word-aligned address)
//   bus_gnt_i            request accepted
//   bus_rvalid_i, bus_rdata_i, bus_err_i   response channel
// -----------------------------------------------------------------------------
module dmem_bus_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_wd_i,
    input  logic [2:0]  mem_funct3_i,
    output logic        stall_o,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;
    logic [2:0]  funct3_q;
    logic        rd_valid_q;
    logic [31:0] rd_data_q;
    logic        err_q;

    logic        buf_q;       // a posted store is draining (REQ/WAIT)
    logic        post_store;  // current IDLE request is posted instead of blocking

    function automatic logic [31:0] load_ext(input logic [2:0]  funct3,
                                             input logic [1:0]  lane,
                                             input logic [31:0] word);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b010:  load_ext = word;
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = 32'd0;
        endcase
    endfunction

`ifdef DMEM_STORE_BUFFER_EN
    // The buffer is only occupied while its drain is in REQ/WAIT, so it is
    // always empty whenever a new request is seen in IDLE.
    assign post_store = mem_req_i && mem_we_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= 1'b0;
        end else if (state == IDLE && post_store) begin
            buf_q <= 1'b1;
        end else if (state == WAIT && bus_rvalid_i) begin
            buf_q <= 1'b0;
        end
    end
`else
    assign post_store = 1'b0;
    assign buf_q      = 1'b0;
`endif

    // During a posted-store drain the pipeline is only held if it presents a
    // new request; that request is accepted in IDLE once the drain retires.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:      stall_o = mem_req_i && !post_store;
            REQ, WAIT: stall_o = buf_q ? mem_req_i : 1'b1;
            default:   stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wd_q       <= 32'd0;
            funct3_q   <= 3'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req_i) begin
                        we_q     <= mem_we_i;
                        addr_q   <= mem_addr_i;
                        be_q     <= mem_we_i ? mem_be_i : 4'b1111;
                        wd_q     <= mem_wd_i;
                        funct3_q <= mem_funct3_i;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt_i) state <= WAIT;
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        // Error pulse lands in DONE for blocking ops, or in the
                        // cycle after rvalid for a posted store.
                        err_q <= bus_err_i;
                        if (!we_q) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= load_ext(funct3_q, addr_q[1:0], bus_rdata_i);
                        end
                        // A drained posted store has already retired.
                        state <= buf_q ? IDLE : DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_req_o   = (state == REQ);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wd_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_bus_master.sv
module tb_dmem_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_i, mem_we_i;
    logic [31:0] mem_addr_i, mem_wd_i;
    logic [3:0]  mem_be_i;
    logic [2:0]  mem_funct3_i;
    logic        stall_o, rd_valid_o, err_o;
    logic [31:0] rd_data_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_rdata_i;

    always #5 clk = ~clk;

    dmem_bus_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req_i    (mem_req_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_be_i     (mem_be_i),
        .mem_wd_i     (mem_wd_i),
        .mem_funct3_i (mem_funct3_i),
        .stall_o      (stall_o),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pipeline instruction list for one run.
    logic        op_we   [2];
    logic [31:0] op_addr [2];
    logic [3:0]  op_be   [2];
    logic [31:0] op_wd   [2];
    logic [2:0]  op_f3   [2];

    // Observations gathered by run().
    int          r_stalls, r_reqs, r_rdv, r_rdv_c, r_first_req_c, r_errs, r_err_done;
    int          r_fields_bad, r_ng;
    logic [31:0] r_rdat, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic        gnt_we [4];

    task automatic set_op(input int i, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input logic [2:0] f3);
        op_we[i] = we; op_addr[i] = addr; op_be[i] = be; op_wd[i] = wd; op_f3[i] = f3;
    endtask

    // Drives n pipeline ops (advancing when one retires) and acts as the bus
    // slave: grants after gw waiting REQ cycles, responds rw cycles after gnt.
    task automatic run(input int n, input int gw, input int rw,
                       input logic [31:0] rdata, input logic rerr);
        int   idx, phase, gcnt, rcnt;
        logic retired, txn_open;
        idx = 0; phase = 0; gcnt = 0; rcnt = 0; retired = 1'b0; txn_open = 1'b0;
        r_stalls = 0; r_reqs = 0; r_rdv = 0; r_rdv_c = -1; r_first_req_c = -1;
        r_errs = 0; r_err_done = 0; r_fields_bad = 0; r_ng = 0; r_rdat = 32'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (retired) idx++;
            if (idx < n) begin
                mem_req_i = 1'b1; mem_we_i = op_we[idx]; mem_addr_i = op_addr[idx];
                mem_be_i = op_be[idx]; mem_wd_i = op_wd[idx]; mem_funct3_i = op_f3[idx];
            end else begin
                mem_req_i = 1'b0;
            end
            #1;
            retired = mem_req_i && !stall_o;
            if (stall_o) r_stalls++;
            if (bus_req_o) begin
                r_reqs++;
                if (r_first_req_c < 0) r_first_req_c = c;
                if (!txn_open) begin
                    txn_open = 1'b1;
                    r_addr = bus_addr_o; r_be = bus_be_o; r_we = bus_we_o; r_wdata = bus_wdata_o;
                end else if (bus_addr_o !== r_addr || bus_be_o !== r_be ||
                             bus_we_o !== r_we || bus_wdata_o !== r_wdata) begin
                    r_fields_bad++;
                end
            end
            if (rd_valid_o) begin
                r_rdv++;
                if (r_rdv_c < 0) r_rdv_c = c;
                r_rdat = rd_data_o;
                if (err_o) r_err_done++;
            end
            if (err_o) r_errs++;
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
            if (phase == 0 && bus_req_o) begin
                if (gcnt == gw) begin
                    bus_gnt_i = 1'b1; phase = 1; rcnt = 0; txn_open = 1'b0;
                    if (r_ng < 4) gnt_we[r_ng] = bus_we_o;
                    r_ng++;
                end else begin
                    gcnt++;
                end
            end else if (phase == 1) begin
                if (rcnt == rw) begin
                    bus_rvalid_i = 1'b1; bus_rdata_i = rdata; bus_err_i = rerr;
                    phase = 0; gcnt = 0;
                end else begin
                    rcnt++;
                end
            end
        end
        @(negedge clk);
        mem_req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] rdata, input logic [31:0] exp);
        set_op(0, 1'b0, addr, 4'b0000, 32'd0, f3);
        run(1, 0, 0, rdata, 1'b0);
        chk({tag, "_data"}, r_rdat, exp);
        chk({tag, "_stall"}, r_stalls, 3);
    endtask

    int cnt;

    initial begin
        rst_n = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_be_i = 4'd0;
        mem_wd_i = 32'd0; mem_funct3_i = 3'd0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'd0; bus_err_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_bus_be", bus_be_o, 0);
        chk("rst_err", err_o, 0);
        mem_req_i = 1'b1;
        #1 chk("rst_stall_follows_req", stall_o, 1);
        mem_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // LW, immediate gnt, rvalid next cycle
        set_op(0, 1'b0, 32'h100, 4'b0000, 32'd0, 3'b010);
        run(1, 0, 0, 32'hDEADBEEF, 1'b0);
        chk("lw_stall", r_stalls, 3);
        chk("lw_req_cycle", r_first_req_c, 1);
        chk("lw_req_count", r_reqs, 1);
        chk("lw_rdv_cycle", r_rdv_c, 3);
        chk("lw_rdv_count", r_rdv, 1);
        chk("lw_data", r_rdat, 32'hDEADBEEF);
        chk("lw_addr", r_addr, 32'h100);
        chk("lw_be", r_be, 4'b1111);
        chk("lw_we", r_we, 0);
        chk("lw_err", r_errs, 0);
        chk("lw_hold", rd_data_o, 32'hDEADBEEF);

        // Load extension
        run_load("lb", 32'h103, 3'b000, 32'h80FF_FFFF, 32'hFFFF_FF80);
        chk("lb_addr", r_addr, 32'h100);
        run_load("lbu", 32'h103, 3'b100, 32'h80FF_FFFF, 32'h0000_0080);
        run_load("lh", 32'h102, 3'b001, 32'h8001_0000, 32'hFFFF_8001);
        run_load("lhu", 32'h102, 3'b101, 32'h8001_0000, 32'h0000_8001);
        run_load("lb_pos", 32'h101, 3'b000, 32'h1234_7F56, 32'h0000_007F);
        run_load("lh_lo", 32'h100, 3'b001, 32'h8001_7FFE, 32'h0000_7FFE);
        run_load("bad_f3", 32'h100, 3'b011, 32'hFFFF_FFFF, 32'h0000_0000);

        // Prime rd_data_o, then check a store leaves it alone
        run_load("lw2", 32'h104, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // SB with gnt held off two cycles
        set_op(0, 1'b1, 32'h101, 4'b0010, 32'h0000_AB00, 3'b000);
        run(1, 2, 0, 32'h0, 1'b0);
        chk("sb_req_cycles", r_reqs, 3);
        chk("sb_fields_stable", r_fields_bad, 0);
        chk("sb_addr", r_addr, 32'h100);
        chk("sb_be", r_be, 4'b0010);
        chk("sb_wdata", r_wdata, 32'h0000_AB00);
        chk("sb_we", r_we, 1);
        chk("sb_rdv", r_rdv, 0);
        chk("sb_rd_hold", rd_data_o, 32'hCAFE_F00D);
`ifdef DMEM_STORE_BUFFER_EN
        chk("sb_stall", r_stalls, 0);
`else
        chk("sb_stall", r_stalls, 5);
`endif

        // Store followed back-to-back by a load
        set_op(0, 1'b1, 32'h200, 4'b1111, 32'h1111_2222, 3'b010);
        set_op(1, 1'b0, 32'h204, 4'b0000, 32'd0, 3'b010);
        run(2, 0, 0, 32'h5A5A_A5A5, 1'b0);
        chk("b2b_txns", r_ng, 2);
        chk("b2b_first_write", gnt_we[0], 1);
        chk("b2b_second_read", gnt_we[1], 0);
        chk("b2b_load_addr", r_addr, 32'h204);
        chk("b2b_rdv", r_rdv, 1);
        chk("b2b_data", r_rdat, 32'h5A5A_A5A5);
`ifdef DMEM_STORE_BUFFER_EN
        chk("b2b_stall", r_stalls, 5);
`else
        chk("b2b_stall", r_stalls, 6);
`endif

        // Load error response, rvalid one cycle late
        set_op(0, 1'b0, 32'h300, 4'b0000, 32'd0, 3'b010);
        run(1, 0, 1, 32'h0BAD_0BAD, 1'b1);
        chk("lerr_count", r_errs, 1);
        chk("lerr_in_done", r_err_done, 1);
        chk("lerr_stall", r_stalls, 4);

        // Store error response
        set_op(0, 1'b1, 32'h304, 4'b1111, 32'h0, 3'b010);
        run(1, 0, 0, 32'h0, 1'b1);
        chk("serr_count", r_errs, 1);

        // Reset while in REQ: bus_req_o drops without a clock edge
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h400; mem_funct3_i = 3'b010;
        @(negedge clk);
        #1 chk("rreq_pre", bus_req_o, 1);
        rst_n = 1'b0; mem_req_i = 1'b0;
        #1;
        chk("rreq_bus_req", bus_req_o, 0);
        chk("rreq_stall", stall_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while in WAIT, then a late response after release
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h408; mem_funct3_i = 3'b010;
        @(negedge clk);
        bus_gnt_i = 1'b1;
        @(negedge clk);
        bus_gnt_i = 1'b0;
        #1 chk("rwait_pre_stall", stall_o, 1);
        rst_n = 1'b0; mem_req_i = 1'b0;
        #1;
        chk("rwait_bus_req", bus_req_o, 0);
        chk("rwait_stall", stall_o, 0);
        chk("rwait_rdv", rd_valid_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h7777_7777;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_rvalid_i = 1'b0;
            #1;
            if (rd_valid_o || stall_o || bus_req_o) cnt++;
        end
        chk("late_rvalid_ignored", cnt, 0);
        chk("late_rd_data", rd_data_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
